// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port integer register file with write-first bypass and a
// per-register busy scoreboard. It sits between decode/issue and writeback.
// Issue marks a destination busy. Writeback stores the result and clears busy.
// Each read port returns operand data plus a hazard flag.
//
// Parameters
//   XLEN  data width in bits
//   NREG  number of architectural registers (power of two, >= 2)
//   AW    register index width, derived from NREG (do not override)
//   NRP   number of read ports (1..4)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset: clears registers and busy bits
//   rs_addr    NRP packed read indices; port p uses [p*AW +: AW]
//   rs_data    NRP packed read data, combinational
//   rs_busy    per-port hazard flag: the addressed register has a pending write
//   iss_valid  issue event; marks iss_rd busy
//   iss_rd     destination register of the issue
//   wb_en      writeback enable
//   wb_rd      writeback destination
//   wb_data    writeback data, stored verbatim
//   flush      clears every busy bit; register data is kept
//   busy_vec   scoreboard state; bit 0 is always 0
//
// Interface timing: there is no valid/ready handshake and no backpressure.
// iss_valid, wb_en and flush are single-cycle events. Each is consumed on the
// rising edge at which it is sampled, and the block never stalls its producers.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG),
    parameter int NRP  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    // Register storage. Entry 0 is held at zero. Reads of index 0 are also
    // forced to zero in the read mux, so the value of entry 0 never matters.
    logic [XLEN-1:0] regs_q [NREG];

    // Scoreboard. One bit per register. Bit 0 is never set.
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A writeback to index 0 is dropped. An issue to index 0 is dropped.
    logic wb_live;
    logic iss_live;

    assign wb_live  = wb_en && (wb_rd != '0);
    assign iss_live = iss_valid && (iss_rd != '0);

    // -------------------------------------------------------------------------
    // Register write
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n || i == 0) begin
                regs_q[i] <= '0;
            end else if (wb_live && wb_rd == AW'(i)) begin
                regs_q[i] <= wb_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // A flush clears everything and also discards a same-cycle issue. The
    // writeback clear is applied before the issue set, so that when both
    // target the same index the new producer keeps the register busy.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_live) begin
                busy_d[wb_rd] = 1'b0;
            end
            if (iss_live) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // -------------------------------------------------------------------------
    // Read ports
    // A writeback that hits the addressed register bypasses storage and reports
    // no hazard, because the producer is completing in this very cycle. The
    // bypass is gated by rst_n. A writeback sampled during reset is discarded,
    // so the port must not forward it.
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = rs_addr[p*AW +: AW];
        assign is_zero = (addr == '0);
        assign hit     = rst_n && wb_en && (wb_rd == addr);

        assign rs_data[p*XLEN +: XLEN] = is_zero ? '0 :
                                         hit     ? wb_data :
                                                   regs_q[addr];
        assign rs_busy[p] = !is_zero && !hit && busy_q[addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp, configured with three read ports.
// A behavioural model (plain arrays) tracks register contents and busy bits.
// The expected busy_vec is queued on each edge. One compare process checks
// every read port and busy_vec on each falling edge. The directed steps add
// hand-computed literal checks. A randomised phase follows them.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int NRP  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NRP*AW-1:0]   rs_addr;
    logic [NRP*XLEN-1:0] rs_data;
    logic [NRP-1:0]      rs_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                wb_en;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg [NREG];
    logic [NREG-1:0] m_busy = '0;
    logic [NREG-1:0] exp_q[$];

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
        end
    end

    // The model advances on each rising edge, from the inputs that were stable
    // before that edge.
    always @(posedge clk) begin : model_update
        logic [NREG-1:0] nb;
        nb = m_busy;
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i] <= '0;
            end
            nb = '0;
        end else begin
            if (wb_en && wb_rd != 0) begin
                m_reg[wb_rd] <= wb_data;
            end
            if (flush) begin
                nb = '0;
            end else begin
                if (wb_en && wb_rd != 0) nb[wb_rd] = 1'b0;
                if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
            end
        end
        m_busy <= nb;
        exp_q.push_back(nb);
    end

    // Expected read result for one port, derived from the model and current inputs.
    function automatic logic [XLEN:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (rst_n && wb_en && wb_rd == a) return {1'b0, wb_data};
        return {m_busy[a], m_reg[a]};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        logic [NREG-1:0] e;
        logic [XLEN:0]   r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (chk_en) check("busy_vec", 64'(busy_vec), 64'(e));
        end else if (chk_en) begin
            check("exp_q_empty", 64'(exp_q.size()), 64'd1);
        end
        if (chk_en) begin
            for (int p = 0; p < NRP; p++) begin
                r = model_read(rs_addr[p*AW +: AW]);
                check($sformatf("rs_data%0d", p), 64'(rs_data[p*XLEN +: XLEN]), 64'(r[XLEN-1:0]));
                check($sformatf("rs_busy%0d", p), 64'(rs_busy[p]), 64'(r[XLEN]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_en     = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a);
        rs_addr[p*AW +: AW] = a;
    endtask

    task automatic do_wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic do_iss(input logic [AW-1:0] rd);
        iss_valid = 1'b1; iss_rd = rd;
    endtask

    function automatic logic [XLEN-1:0] port_data(input int p);
        return rs_data[p*XLEN +: XLEN];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; rs_addr = '0; iss_valid = 1'b0; iss_rd = '0;
        flush = 1'b0; do_wb(4'd3, 32'hDEADBEEF);
        next_cycle();
        next_cycle();
        // Reset has covered two edges. The writeback held during reset must be lost.
        rst_n = 1'b1; idle(); chk_en = 1'b1;
        set_port(0, 4'd3);
        @(negedge clk);
        check("reset_reg3", 64'(port_data(0)), 64'h0);
        check("reset_busy_vec", 64'(busy_vec), 64'h0);

        // Write with same-cycle bypass, then read back from storage.
        next_cycle(); do_wb(4'd5, 32'h12345678); set_port(0, 4'd5);
        @(negedge clk);
        check("bypass_r5", 64'(port_data(0)), 64'h12345678);
        check("bypass_r5_busy", 64'(rs_busy[0]), 64'h0);
        next_cycle(); idle();
        @(negedge clk);
        check("stored_r5", 64'(port_data(0)), 64'h12345678);

        // A write to register 0 is dropped.
        next_cycle(); do_wb(4'd0, 32'hFFFFFFFF); set_port(0, 4'd0);
        @(negedge clk);
        check("r0_bypass_blocked", 64'(port_data(0)), 64'h0);
        next_cycle(); idle();
        @(negedge clk);
        check("r0_reads_zero", 64'(port_data(0)), 64'h0);

        // Issue, then writeback clears busy in the same cycle.
        next_cycle(); do_iss(4'd7); set_port(1, 4'd7);
        next_cycle(); idle();
        @(negedge clk);
        check("iss7_rs_busy", 64'(rs_busy[1]), 64'h1);
        check("iss7_busy_vec", 64'(busy_vec), 64'h0080);
        next_cycle(); do_wb(4'd7, 32'hA5);
        @(negedge clk);
        check("wb7_rs_busy", 64'(rs_busy[1]), 64'h0);
        check("wb7_rs_data", 64'(port_data(1)), 64'hA5);
        next_cycle(); idle();
        @(negedge clk);
        check("wb7_busy_vec", 64'(busy_vec), 64'h0);

        // Issue and writeback to the same register: the issue keeps it busy.
        next_cycle(); do_iss(4'd9);
        next_cycle(); do_iss(4'd9); do_wb(4'd9, 32'h99); set_port(0, 4'd9);
        next_cycle(); idle();
        @(negedge clk);
        check("same_rd_busy_vec", 64'(busy_vec), 64'h0200);
        check("same_rd_data", 64'(port_data(0)), 64'h99);
        check("same_rd_rs_busy", 64'(rs_busy[0]), 64'h1);
        next_cycle(); do_wb(4'd9, 32'h1);
        next_cycle(); idle(); do_iss(4'd0);
        next_cycle(); idle();
        @(negedge clk);
        check("iss_r0_busy_vec", 64'(busy_vec), 64'h0);

        // A flush clears the scoreboard and drops a same-cycle issue.
        next_cycle(); do_iss(4'd2);
        next_cycle(); do_iss(4'd4);
        next_cycle(); do_iss(4'd6);
        next_cycle(); idle();
        @(negedge clk);
        check("pre_flush_busy_vec", 64'(busy_vec), 64'h0054);
        next_cycle(); flush = 1'b1; do_iss(4'd8); set_port(2, 4'd8);
        next_cycle(); idle();
        @(negedge clk);
        check("flush_busy_vec", 64'(busy_vec), 64'h0);
        check("flush_r8_busy", 64'(rs_busy[2]), 64'h0);

        // Every port reads the same register.
        next_cycle(); do_wb(4'd11, 32'hCAFE0000);
        next_cycle(); idle(); do_iss(4'd11);
        for (int p = 0; p < NRP; p++) set_port(p, 4'd11);
        @(negedge clk);
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("mp_data%0d", p), 64'(port_data(p)), 64'hCAFE0000);
            check($sformatf("mp_free%0d", p), 64'(rs_busy[p]), 64'h0);
        end
        next_cycle(); idle();
        @(negedge clk);
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("mp_busy%0d", p), 64'(rs_busy[p]), 64'h1);
        end

        // Reset asserted mid-operation. Bypass is suppressed while rst_n is low.
        next_cycle(); do_iss(4'd12);
        next_cycle(); idle(); rst_n = 1'b0; do_wb(4'd5, 32'h55555555); set_port(0, 4'd5);
        @(negedge clk);
        check("rst_no_bypass", 64'(port_data(0)), 64'h12345678);
        next_cycle(); rst_n = 1'b1; idle();
        @(negedge clk);
        check("rst_r5_cleared", 64'(port_data(0)), 64'h0);
        check("rst_busy_vec", 64'(busy_vec), 64'h0);

        // Randomised traffic, checked by the compare process each cycle.
        for (int c = 0; c < 800; c++) begin
            next_cycle();
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = AW'($urandom_range(0, NREG - 1));
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_rd     = AW'($urandom_range(0, NREG - 1));
            wb_data   = $urandom;
            for (int p = 0; p < NRP; p++) begin
                set_port(p, AW'($urandom_range(0, NREG - 1)));
            end
        end
        next_cycle(); idle(); rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with write-first bypass and a per-register busy scoreboard. It sits in the core between decode/issue and writeback. Issue marks a destination register busy; writeback stores the result and clears busy. Read ports return operand data together with a hazard flag, so issue logic can stall without a separate scoreboard.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 16, number of architectural registers; must be a power of two and ≥ 2.
- AW, $clog2(NREG), register index width (derived; do not override).
- NRP, 2, number of read ports (1–4).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rs_addr  input  NRP*AW  read indices; port p uses bits [p*AW +: AW].
- rs_data  output  NRP*XLEN  read data for each port (combinational).
- rs_busy  output  NRP  per-port flag: the addressed register has a pending write.
- iss_valid  input  1  issue event: mark iss_rd busy.
- iss_rd  input  AW  destination register being issued.
- wb_en  input  1  writeback enable.
- wb_rd  input  AW  writeback destination.
- wb_data  input  XLEN  writeback data.
- flush  input  1  clear all busy bits (pipeline flush); register data is unchanged.
- busy_vec  output  NREG  current scoreboard state; bit 0 is always 0.

## Operation
- Storage: NREG × XLEN registers and NREG busy bits. Register 0 is hardwired:
  - reads as 0;
  - writes to it are dropped;
  - issue to it is dropped;
  - busy bit 0 is constant 0.
- Read port p, combinational:
  - rs_addr_p == 0 → rs_data_p = 0, rs_busy_p = 0.
  - Otherwise, if wb_en && wb_rd == rs_addr_p → bypass: rs_data_p = wb_data, rs_busy_p = 0. An issue to the same index in the same cycle does not affect this port's flags that cycle.
  - Otherwise → rs_data_p = reg[rs_addr_p], rs_busy_p = busy[rs_addr_p].
- Write, at the clock edge: if rst_n && wb_en && wb_rd != 0, then reg[wb_rd] ← wb_data.
- Scoreboard update at each clock edge, in priority order (highest first):
  1. !rst_n → all busy bits cleared.
  2. flush → all busy bits cleared; iss_valid is ignored that cycle. Any wb_en in the same cycle still writes data.
  3. Otherwise:
     - wb_en (wb_rd != 0) clears busy[wb_rd].
     - iss_valid (iss_rd != 0) sets busy[iss_rd].
     - If iss_rd == wb_rd in the same cycle, set wins: busy stays 1 for the new producer.
- Issuing to a register that is already busy is legal (WAW): busy stays 1, and the next writeback clears it. Ordering of in-flight writers is the issue logic's responsibility.
- Writeback to a register that is not busy is legal: data is written, busy stays 0.
- Arithmetic: no width conversion; wb_data is stored verbatim. Indices are always in range because NREG = 2^AW.

## Timing
- Reset (rst_n low at an edge):
  - all registers ← 0, all busy ← 0; busy_vec = 0 from the next cycle;
  - wb and issue inputs are ignored.
  - Read outputs stay combinational during reset. Bypass is suppressed while rst_n = 0, so reads return stored values.
  - Reset asserted mid-operation discards pending writes and busy state in the same edge.
- Write latency: 0 cycles to read ports via bypass; data is in storage from the cycle after the edge.
- Issue latency: busy visible on rs_busy/busy_vec from the cycle after iss_valid.
- Busy clear: same cycle via bypass on rs_busy; in busy_vec from the next cycle.
- No handshakes or backpressure: every input event is consumed on the edge where it is sampled.
- Multiple read ports may address the same register; each gets identical results.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with wb_en = 1, wb_rd = 3, wb_data = 32'hDEADBEEF → after release, reg 3 reads 0 and busy_vec = 0.
- Write/read with bypass:
  - wb_en, wb_rd = 5, wb_data = 32'h12345678, rs_addr port0 = 5 in the same cycle → rs_data0 = 32'h12345678 that cycle and every later cycle.
  - wb_rd = 0, wb_data = 32'hFFFFFFFF → reg 0 still reads 0.
- Scoreboard:
  - iss_valid, iss_rd = 7 → next cycle rs_busy = 1 on a port reading 7, and busy_vec = 16'h0080.
  - wb_en, wb_rd = 7, wb_data = 32'hA5 → rs_busy = 0 and rs_data = 32'hA5 in that cycle; busy_vec = 0 next cycle.
- Simultaneous events:
  - With reg 9 busy: iss_rd = 9 and wb_rd = 9 in the same cycle → data written, busy[9] stays 1.
  - iss_rd = 0 → busy_vec bit 0 stays 0.
- Flush: busy regs 2, 4, 6; then flush = 1 together with iss_valid, iss_rd = 8 → busy_vec = 0 next cycle and reg 8 is not busy.
- Multi-port: with NRP = 3, all ports read reg 11 = 32'hCAFE0000 → all ports return 32'hCAFE0000 with matching busy flags. Randomised issue/writeback checked against a reference-model scoreboard.
